// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding and default line parameters
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
  localparam int CLK_FREQ_HZ = 100_000_000;
  localparam int BAUD_RATE = 9600;
  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS = 8;
endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: received-byte handshake and error pulses between receiver and consumer
interface uart_rx_if;
  import uart_pkg::*;
  logic [DATA_BITS-1:0] rx_data;
  logic rx_valid;
  logic rx_ready;
  logic frame_err;
  logic overrun;
  modport master(output rx_data, rx_valid, frame_err, overrun, input rx_ready);
  modport slave(input rx_data, rx_valid, frame_err, overrun, output rx_ready);
endinterface

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: free-running divider emitting a one-clk tick every DIV clocks
module baud_tick_gen #(
  parameter int DIV = 651
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int W = DIV > 1 ? $clog2(DIV) : 1;
  logic [W-1:0] cnt_q, cnt_d;
  assign tick = cnt_q == W'(DIV - 1);
  assign cnt_d = tick ? '0 : cnt_q + 1'b1;
  // wrap the divider count on every tick
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling 8N1 receiver with ready/valid holding register and error pulses
module uart_rx #(
  parameter int CLK_FREQ_HZ = uart_pkg::CLK_FREQ_HZ,
  parameter int BAUD_RATE = uart_pkg::BAUD_RATE,
  parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      rx,
  uart_rx_if.master rx_if
);
  import uart_pkg::*;
  localparam int DIV = CLK_FREQ_HZ / (BAUD_RATE * OVERSAMPLE);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  rx_state_t state_q, state_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
  logic [1:0] sync_q, arm_q;
  logic prev_q, valid_q, valid_d, ferr_q, ferr_d, ovr_q, ovr_d;
  logic tick, rx_s, fall, samp, good, load;
  baud_tick_gen #(.DIV(DIV)) u_tick (.clk(clk), .rst(rst), .tick(tick));
  assign rx_s = sync_q[1];
  assign fall = prev_q & ~rx_s;
  // synchronize rx; prev only arms once real line samples reach it, so a line held low out of reset never looks like an edge
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync_q <= 2'b11;
      arm_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], rx};
      arm_q <= {arm_q[0], 1'b1};
      prev_q <= rx_s & arm_q[1];
    end
  // frame sequencing: start check at mid start bit, then one sample per bit period
  always_comb begin
    state_d = state_q;
    tcnt_d = tcnt_q;
    bcnt_d = bcnt_q;
    shift_d = shift_q;
    samp = 1'b0;
    case (state_q)
      IDLE: if (fall) begin
        state_d = START;
        tcnt_d = '0;
        bcnt_d = '0;
      end
      START: if (tick) begin
        tcnt_d = tcnt_q == TW'(OVERSAMPLE / 2 - 1) ? '0 : tcnt_q + 1'b1;
        if (tcnt_q == TW'(OVERSAMPLE / 2 - 1)) state_d = rx_s ? IDLE : DATA;
      end
      DATA: if (tick) begin
        tcnt_d = tcnt_q + 1'b1;
        if (tcnt_q == TW'(OVERSAMPLE - 1)) begin
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          bcnt_d = bcnt_q + 1'b1;
          if (bcnt_q == BW'(DATA_BITS - 1)) state_d = STOP;
        end
      end
      STOP: if (tick) begin
        tcnt_d = tcnt_q + 1'b1;
        if (tcnt_q == TW'(OVERSAMPLE - 1)) begin
          samp = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  assign good = samp & rx_s;
  assign load = good & (~valid_q | rx_if.rx_ready);
  assign valid_d = load | (valid_q & ~rx_if.rx_ready);
  assign data_d = load ? shift_q : data_q;
  assign ferr_d = samp & ~rx_s;
  assign ovr_d = good & valid_q & ~rx_if.rx_ready;
  // frame state and holding register
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      tcnt_q <= '0;
      bcnt_q <= '0;
      shift_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
      ferr_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tcnt_q <= tcnt_d;
      bcnt_q <= bcnt_d;
      shift_q <= shift_d;
      data_q <= data_d;
      valid_q <= valid_d;
      ferr_q <= ferr_d;
      ovr_q <= ovr_d;
    end
  assign rx_if.rx_data = data_q;
  assign rx_if.rx_valid = valid_q;
  assign rx_if.frame_err = ferr_q;
  assign rx_if.overrun = ovr_q;
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The module SHALL have parameter CLK_FREQ_HZ, default 100_000_000, system clock frequency in Hz.
REQ-002 The module SHALL have parameter BAUD_RATE, default 9600, serial bit rate.
REQ-003 The module SHALL have parameter OVERSAMPLE, default 16, sample ticks per bit.
REQ-004 The module SHALL have port clk, input, 1 bit, single system clock, rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit, reset; one clock, asynchronous, active-high.
REQ-006 The module SHALL have port rx, input, 1 bit, asynchronous serial line, idle high.
REQ-007 The module SHALL have port rx_data, output, 8 bits, received byte, valid while rx_valid=1.
REQ-008 The module SHALL have port rx_valid, output, 1 bit, byte available to the downstream FIFO.
REQ-009 The module SHALL have port rx_ready, input, 1 bit, downstream accepts rx_data this cycle.
REQ-010 The module SHALL have port frame_err, output, 1 bit, one-cycle pulse on a bad stop bit.
REQ-011 The module SHALL have port overrun, output, 1 bit, one-cycle pulse when a completed byte is dropped.

Function
REQ-012 rx SHALL pass through a 2-FF synchronizer before any use; both flops reset to 1.
REQ-013 The tick generator SHALL count 0..DIV-1, where DIV = CLK_FREQ_HZ/(BAUD_RATE*OVERSAMPLE) with integer truncation (651 at defaults), and pulse tick for one clk when count = DIV-1; it SHALL be free-running.
REQ-014 The FSM SHALL have exactly the states IDLE, START, DATA and STOP.
REQ-015 IDLE SHALL move to START on a synchronized falling edge (previous 1, current 0) and clear the tick counter and bit counter; a line that is held low SHALL NOT start a frame.
REQ-016 In START, on the tick at which the count reaches OVERSAMPLE/2-1 (the 8th tick, mid start bit): if rx=0, the FSM SHALL go to DATA and clear the tick count; if rx=1, it SHALL return to IDLE (glitch rejection).
REQ-017 In DATA, every OVERSAMPLE ticks the FSM SHALL shift rx into the shift register, LSB first; after the 8th bit it SHALL go to STOP.
REQ-018 In STOP, after OVERSAMPLE ticks, rx SHALL be sampled: rx=1 means frame good; rx=0 means frame_err=1 for one clk, the byte is discarded, and rx_valid is unchanged. The FSM SHALL then return to IDLE.
REQ-019 On a good frame, the byte SHALL load into the holding register and rx_valid SHALL be 1 on the clk edge following the stop-sample tick (latency ~9.5 bit periods from the start edge).
REQ-020 rx_valid SHALL stay 1, with rx_data stable, until a cycle with rx_valid && rx_ready; it SHALL fall the next edge unless a new byte loads in that same cycle.
REQ-021 If a good frame completes while rx_valid=1 and rx_ready=0: the old byte SHALL be retained, the new byte dropped, and overrun=1 for one clk.
REQ-022 If a good frame completes in the same cycle as a handshake: the new byte SHALL load, rx_valid SHALL stay 1, and there SHALL be no overrun.
REQ-023 frame_err and overrun SHALL never be asserted in the same cycle (they are mutually exclusive by construction).

Reset
REQ-024 On rst=1 (asynchronous), the FSM SHALL go to IDLE; tick count, bit count, shift register, rx_data, rx_valid, frame_err and overrun SHALL be 0; synchronizer flops SHALL be 1.
REQ-025 On reset mid-frame, the in-flight byte SHALL be discarded; after release, the next falling edge SHALL start a new frame, and a line still low SHALL be ignored per REQ-015.

Structure
REQ-026 Package uart_pkg SHALL hold the rx_state_t enum (IDLE, START, DATA, STOP) and the defaults CLK_FREQ_HZ, BAUD_RATE, OVERSAMPLE and DATA_BITS=8, for reuse by the transmitter.
REQ-027 The tick generator SHALL be the sub-module baud_tick_gen (ports clk, rst, tick; parameter DIV), shared with uart_tx.

Verification
REQ-028 Send 0x55 at 9600 baud (bit period 104160 ns), rx_ready=1 -> rx_valid pulses once with rx_data=0x55, within 10 bit periods of the start edge.
REQ-029 Drive a 3 us low glitch on idle rx -> FSM returns to IDLE, with no rx_valid and no frame_err.
REQ-030 Send 0xA3 with stop bit forced 0 -> frame_err pulses once and rx_valid stays 0; a following good 0x3C is received correctly.
REQ-031 With rx_ready=0, send 0x11 then 0x22 -> rx_data stays 0x11 and overrun pulses once at the end of 0x22; a handshake then drops rx_valid.
REQ-032 With rx_ready=1, send 256 back-to-back random bytes -> all 256 match in order, with zero frame_err and zero overrun.
REQ-033 Assert rst for 100 ns during data bit 4 of 0xF0, then send 0x0F -> all outputs are 0 during reset and exactly one byte, 0x0F, is received.
